// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter.
// One shared resource, CLIENTS requesters. A client holds the grant for up to
// its weight in non-stalled cycles, then the grant rotates to the next
// requester after it. Grant, grant_valid and grant_id are registered.
//
// Handshake: request[i] is a level that client i holds high while it wants the
// resource. grant[i] high means client i owns the resource this cycle. Every
// cycle with stall low, grant[o] high and request[o] high uses one unit of the
// owner's burst. While stall is high nothing moves: no burst is used, no grant
// changes and the pointer holds.
//
// The dbg_* outputs show the internal state (FSM state, round-robin pointer and
// burst counter). They carry no function.
module wrr_arbiter #(
   parameter int CLIENTS  = 8,
   parameter int WEIGHT_W = 4,
   parameter int IDX_W    = $clog2(CLIENTS)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [CLIENTS-1:0]           request,
   input  logic [CLIENTS*WEIGHT_W-1:0]  weight,
   input  logic                         stall,
   output logic [CLIENTS-1:0]           grant,
   output logic                         grant_valid,
   output logic [IDX_W-1:0]             grant_id,
   output logic                         dbg_owned,
   output logic [IDX_W-1:0]             dbg_ptr,
   output logic [WEIGHT_W-1:0]          dbg_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   // Used to wrap ptr+k modulo CLIENTS. This also works when CLIENTS is not a power of two.
   localparam logic [IDX_W:0]    CLIENTS_X = (IDX_W+1)'(CLIENTS);
   localparam logic [IDX_W-1:0]  LAST_IDX  = (IDX_W)'(CLIENTS - 1);
   localparam logic [WEIGHT_W-1:0] CNT_ONE = (WEIGHT_W)'(1);

   state_t               state;
   logic [IDX_W-1:0]     ptr;
   logic [WEIGHT_W-1:0]  cnt;

   // Per-client weight fields, unpacked from the flat bus.
   logic [WEIGHT_W-1:0]  wt [CLIENTS];

   // Arbitration signals for the current cycle.
   logic [IDX_W-1:0]     next_ptr;   // pointer the owner leaves behind on release
   logic [IDX_W-1:0]     arb_ptr;    // starting point of this cycle's search
   logic                 keep;       // owner keeps the grant and uses one unit
   logic [IDX_W:0]       cand;
   logic [IDX_W-1:0]     win;
   logic                 found;
   logic [WEIGHT_W-1:0]  wt_win;
   logic [WEIGHT_W-1:0]  win_load;
   logic [CLIENTS-1:0]   win_onehot;

   for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_wt
      assign wt[gi] = weight[gi*WEIGHT_W +: WEIGHT_W];
   end

   assign dbg_owned = (state == OWNED);
   assign dbg_ptr   = ptr;
   assign dbg_cnt   = cnt;

   // Release and search-start decision for the current owner.
   always_comb begin
      next_ptr = (grant_id == LAST_IDX) ? '0 : grant_id + (IDX_W)'(1);
      keep     = (state == OWNED) && request[grant_id] && (cnt > CNT_ONE);
      // On release, the search starts just past the owner in the same cycle.
      // That is why there is no idle bubble between two owners.
      arb_ptr  = (state == OWNED) ? next_ptr : ptr;
   end

   // Round-robin search: find the first request at or after arb_ptr, wrapping around.
   always_comb begin
      cand  = '0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < CLIENTS; k++) begin
         cand = {1'b0, arb_ptr} + (IDX_W+1)'(k);
         if (cand >= CLIENTS_X) begin
            cand = cand - CLIENTS_X;
         end
         if (!found && request[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            win   = cand[IDX_W-1:0];
         end
      end
   end

   // Winner burst load and one-hot grant. A weight of zero counts as one so
   // that cnt never underflows.
   always_comb begin
      wt_win          = wt[win];
      win_load        = (wt_win == '0) ? CNT_ONE : wt_win;
      win_onehot      = '0;
      win_onehot[win] = 1'b1;
   end

   // Arbiter FSM: grant ownership, burst accounting and pointer rotation.
   // The whole FSM is frozen while stall is high.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         cnt         <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
      end else if (!stall) begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant       <= win_onehot;
                  grant_valid <= 1'b1;
                  grant_id    <= win;
                  cnt         <= win_load;
                  state       <= OWNED;
               end
            end
            OWNED: begin
               if (keep) begin
                  cnt <= cnt - CNT_ONE;
               end else begin
                  ptr <= next_ptr;
                  if (found) begin
                     grant       <= win_onehot;
                     grant_valid <= 1'b1;
                     grant_id    <= win;
                     cnt         <= win_load;
                  end else begin
                     grant       <= '0;
                     grant_valid <= 1'b0;
                     grant_id    <= '0;
                     state       <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter with CLIENTS=8 and WEIGHT_W=4.
// It applies a table of hand-derived vectors, then a reset in the middle of a
// burst, then a fairness run, then random traffic checked against a model.
module tb_wrr_arbiter;

   localparam int N = 8;
   localparam int W = 4;

   logic          clock;
   logic          reset;
   logic [N-1:0]  request;
   logic [N*W-1:0] weight;
   logic          stall;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [2:0]    grant_id;
   logic          dbg_owned;
   logic [2:0]    dbg_ptr;
   logic [W-1:0]  dbg_cnt;

   int checks   = 0;
   int failures = 0;

   wrr_arbiter #(.CLIENTS(N), .WEIGHT_W(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .request     (request),
      .weight      (weight),
      .stall       (stall),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .dbg_owned   (dbg_owned),
      .dbg_ptr     (dbg_ptr),
      .dbg_cnt     (dbg_cnt)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Comparison helper
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Vector table
   typedef struct {
      logic          rst;
      logic [7:0]    req;
      logic          stl;
      logic [31:0]   wt;
      logic [7:0]    exp_grant;
      logic [2:0]    exp_id;
      logic [2:0]    exp_ptr;
      logic          chk_cnt;
      logic [3:0]    exp_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input logic r, input logic [7:0] rq, input logic st,
                                   input logic [31:0] w, input logic [7:0] g, input logic [2:0] id,
                                   input logic [2:0] p, input logic cc, input logic [3:0] c);
      vec_t v;
      v.rst = r; v.req = rq; v.stl = st; v.wt = w;
      v.exp_grant = g; v.exp_id = id; v.exp_ptr = p; v.chk_cnt = cc; v.exp_cnt = c;
      vecs.push_back(v);
   endfunction

   // Reference model: owner, remaining burst and pointer, written directly from the arbitration rules
   int m_owner;
   int m_rem;
   int m_ptr;

   task automatic model_step(input logic [7:0] rq, input logic [31:0] wt, input logic st, input logic rs);
      int c;
      int wv;
      if (rs) begin
         m_owner = -1; m_rem = 0; m_ptr = 0;
         return;
      end
      if (st) return;
      if (m_owner >= 0 && rq[m_owner] && m_rem > 1) begin
         m_rem = m_rem - 1;
         return;
      end
      if (m_owner >= 0) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
      end
      for (int k = 0; k < N; k++) begin
         c = (m_ptr + k) % N;
         if (rq[c]) begin
            wv      = int'(wt[c*W +: W]);
            m_owner = c;
            m_rem   = (wv == 0) ? 1 : wv;
            return;
         end
      end
   endtask

   function automatic logic [7:0] model_grant();
      logic [7:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   function automatic bit is_onehot0(input logic [7:0] g);
      return (g & (g - 8'd1)) == 8'd0;
   endfunction

   // Stimulus and checking
   initial begin
      int gap [N];
      int bound [N];
      bit seen [N];
      logic [31:0] fw;
      logic [7:0] g;
      logic [7:0] rq;
      logic st, rs;

      reset = 1'b1; request = '0; weight = '0; stall = 1'b0;
      #1;
      check("reset_grant", 32'(grant), 32'h0);
      check("reset_valid", 32'(grant_valid), 32'h0);
      check("reset_id", 32'(grant_id), 32'h0);

      // Two requesters with weights 2 and 1: 02 02 04 repeating.
      add_vec(1, 8'h00, 0, 32'h0000_0120, 8'h00, 3'd0, 3'd0, 1, 4'd0);
      add_vec(0, 8'h06, 0, 32'h0000_0120, 8'h02, 3'd1, 3'd0, 1, 4'd2);
      add_vec(0, 8'h06, 0, 32'h0000_0120, 8'h02, 3'd1, 3'd0, 1, 4'd1);
      add_vec(0, 8'h06, 0, 32'h0000_0120, 8'h04, 3'd2, 3'd2, 1, 4'd1);
      add_vec(0, 8'h06, 0, 32'h0000_0120, 8'h02, 3'd1, 3'd3, 1, 4'd2);
      add_vec(0, 8'h06, 0, 32'h0000_0120, 8'h02, 3'd1, 3'd3, 1, 4'd1);
      add_vec(0, 8'h06, 0, 32'h0000_0120, 8'h04, 3'd2, 3'd2, 1, 4'd1);
      // Single requester 4 with weight 3: continuous grant, cnt reloads, ptr goes to 5.
      add_vec(1, 8'h00, 0, 32'h0003_0000, 8'h00, 3'd0, 3'd0, 1, 4'd0);
      add_vec(0, 8'h10, 0, 32'h0003_0000, 8'h10, 3'd4, 3'd0, 1, 4'd3);
      add_vec(0, 8'h10, 0, 32'h0003_0000, 8'h10, 3'd4, 3'd0, 1, 4'd2);
      add_vec(0, 8'h10, 0, 32'h0003_0000, 8'h10, 3'd4, 3'd0, 1, 4'd1);
      add_vec(0, 8'h10, 0, 32'h0003_0000, 8'h10, 3'd4, 3'd5, 1, 4'd3);
      add_vec(0, 8'h10, 0, 32'h0003_0000, 8'h10, 3'd4, 3'd5, 1, 4'd2);
      add_vec(0, 8'h10, 0, 32'h0003_0000, 8'h10, 3'd4, 3'd5, 1, 4'd1);
      add_vec(0, 8'h10, 0, 32'h0003_0000, 8'h10, 3'd4, 3'd5, 1, 4'd3);
      // Early drop: client 3 (weight 4) drops after one cycle. Client 6 (weight 0) holds the grant for one cycle.
      add_vec(1, 8'h00, 0, 32'h0000_4000, 8'h00, 3'd0, 3'd0, 1, 4'd0);
      add_vec(0, 8'h08, 0, 32'h0000_4000, 8'h08, 3'd3, 3'd0, 1, 4'd4);
      add_vec(0, 8'h40, 0, 32'h0000_4000, 8'h40, 3'd6, 3'd4, 1, 4'd1);
      add_vec(0, 8'h00, 0, 32'h0000_4000, 8'h00, 3'd0, 3'd7, 0, 4'd0);
      // Stall in the middle of a burst for client 0 (weight 3).
      add_vec(1, 8'h00, 0, 32'h0000_0003, 8'h00, 3'd0, 3'd0, 1, 4'd0);
      add_vec(0, 8'h01, 0, 32'h0000_0003, 8'h01, 3'd0, 3'd0, 1, 4'd3);
      add_vec(0, 8'h01, 0, 32'h0000_0003, 8'h01, 3'd0, 3'd0, 1, 4'd2);
      for (int i = 0; i < 5; i++)
         add_vec(0, 8'h01, 1, 32'h0000_0003, 8'h01, 3'd0, 3'd0, 1, 4'd2);
      add_vec(0, 8'h01, 0, 32'h0000_0003, 8'h01, 3'd0, 3'd0, 1, 4'd1);
      add_vec(0, 8'h01, 0, 32'h0000_0003, 8'h01, 3'd0, 3'd1, 1, 4'd3);
      // Stall while idle, with every client requesting.
      add_vec(1, 8'h00, 0, 32'h0000_0003, 8'h00, 3'd0, 3'd0, 1, 4'd0);
      for (int i = 0; i < 3; i++)
         add_vec(0, 8'hFF, 1, 32'h0000_0003, 8'h00, 3'd0, 3'd0, 1, 4'd0);
      add_vec(0, 8'hFF, 0, 32'h0000_0003, 8'h01, 3'd0, 3'd0, 1, 4'd3);
      // Wrap-around: all clients requesting, weights 1 and then 0. Grant rotates 01 to 80 and back.
      add_vec(1, 8'h00, 0, 32'h1111_1111, 8'h00, 3'd0, 3'd0, 1, 4'd0);
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < N; k++)
            add_vec(0, 8'hFF, 0, (r == 0) ? 32'h1111_1111 : 32'h0, 8'(1 << k), 3'(k), 3'(k), 1, 4'd1);
      add_vec(0, 8'hFF, 0, 32'h0, 8'h01, 3'd0, 3'd0, 1, 4'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         reset = vecs[i].rst; request = vecs[i].req; stall = vecs[i].stl; weight = vecs[i].wt;
         @(posedge clock); #1;
         check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
         check($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(vecs[i].exp_grant != 8'h00));
         check($sformatf("vec%0d_id", i), 32'(grant_id), 32'(vecs[i].exp_id));
         check($sformatf("vec%0d_ptr", i), 32'(dbg_ptr), 32'(vecs[i].exp_ptr));
         if (vecs[i].chk_cnt)
            check($sformatf("vec%0d_cnt", i), 32'(dbg_cnt), 32'(vecs[i].exp_cnt));
      end

      // Reset in the middle of a burst must drop the grant without waiting for a clock edge.
      @(negedge clock); reset = 1'b1;
      @(negedge clock); reset = 1'b0; weight = 32'h0000_0300; request = 8'h04; stall = 1'b0;
      @(posedge clock); #1;
      check("mid_grant_pre", 32'(grant), 32'h04);
      @(posedge clock); #1;
      check("mid_cnt_pre", 32'(dbg_cnt), 32'h2);
      @(negedge clock); #2; reset = 1'b1; #1;
      check("mid_async_grant", 32'(grant), 32'h0);
      check("mid_async_valid", 32'(grant_valid), 32'h0);
      check("mid_async_id", 32'(grant_id), 32'h0);
      @(negedge clock); reset = 1'b0; request = 8'h05;
      @(posedge clock); #1;
      check("mid_after_grant", 32'(grant), 32'h01);
      check("mid_after_id", 32'(grant_id), 32'h0);

      // Fairness: all clients requesting with random fixed weights. Check the wait of each client against its bound.
      @(negedge clock); reset = 1'b1;
      fw = $urandom;
      @(negedge clock); reset = 1'b0; weight = fw; request = 8'hFF; stall = 1'b0;
      for (int i = 0; i < N; i++) begin
         bound[i] = 0; gap[i] = 0; seen[i] = 0;
         for (int j = 0; j < N; j++)
            if (j != i) bound[i] += (fw[j*W +: W] == 0) ? 1 : int'(fw[j*W +: W]);
      end
      for (int c = 0; c < 250; c++) begin
         @(posedge clock); #1;
         for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
               if (!seen[i] || gap[i] > 0)
                  check($sformatf("fair_gap_ok%0d(gap=%0d,bound=%0d)", i, gap[i], bound[i]),
                        32'(gap[i] <= bound[i]), 32'h1);
               seen[i] = 1; gap[i] = 0;
            end else begin
               gap[i]++;
            end
         end
      end

      // Random traffic compared with the reference model
      @(negedge clock); reset = 1'b1; stall = 1'b0; request = '0;
      model_step(8'h00, 32'h0, 1'b0, 1'b1);
      @(posedge clock); #1;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clock);
         rs = ($urandom_range(0, 299) == 0);
         st = ($urandom_range(0, 4) == 0);
         rq = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 3) == 0) rq = '0;
         if ($urandom_range(0, 49) == 0) weight = $urandom;
         reset = rs; stall = st; request = rq;
         model_step(rq, weight, st, rs);
         @(posedge clock); #1;
         g = model_grant();
         check("rand_grant", 32'(grant), 32'(g));
         check("rand_valid", 32'(grant_valid), 32'(g != 8'h00));
         check("rand_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'h0);
         check("rand_onehot", 32'(is_onehot0(grant)), 32'h1);
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Weighted round-robin arbiter that shares a single resource between CLIENTS requesters.
- Each grant is held for up to a per-client burst length (weight) before the grant moves to the next requester in round-robin order.
- Sits in front of a shared datapath. A downstream stall freezes arbitration and the burst accounting.
- Grant is registered and one-hot, with a binary index of the owner alongside it.

Parameters:
- CLIENTS, 8, number of requesters; legal range 2..32.
- WEIGHT_W, 4, width of each per-client weight field.
- IDX_W, $clog2(CLIENTS), width of grant_id (derived; do not override).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- request  input  CLIENTS  per-client request level; a client holds it high while it wants the resource.
- weight  input  CLIENTS*WEIGHT_W  burst length per client; client i uses bits [i*WEIGHT_W +: WEIGHT_W]. Quasi-static: sampled only when a new grant is issued. A value of 0 is treated as 1.
- stall  input  1  downstream backpressure; freezes all arbiter state.
- grant  output  CLIENTS  registered one-hot grant, or all zeros.
- grant_valid  output  1  high iff grant is nonzero (registered).
- grant_id  output  IDX_W  index of the granted client; 0 when grant_valid is low.

Behaviour:
- Reset (asynchronous, immediate):
  - grant=0, grant_valid=0, grant_id=0.
  - Round-robin pointer ptr=0, burst counter cnt=0, state=IDLE.
  - Reset asserted mid-burst drops the grant at once. After reset deassertion, arbitration restarts from ptr=0.
- State machine: IDLE and OWNED.
- IDLE:
  - If stall=0 and request!=0, select winner w = the first set request bit scanning ptr, ptr+1, …, wrapping modulo CLIENTS.
  - At the next edge: grant=onehot(w), grant_id=w, cnt=max(weight[w],1), state=OWNED.
  - With stall=1 or request=0, remain in IDLE with grant=0.
  - Latency: request rising in cycle N (arbiter idle, no stall) gives grant in cycle N+1.
- OWNED, with owner o:
  - stall=1: grant, grant_id, cnt, ptr and state all hold. Nothing is consumed.
  - stall=0 and request[o]=1 and cnt>1: cnt decrements; grant holds.
  - stall=0 and (request[o]=0 or cnt==1): release. ptr=(o+1) mod CLIENTS. Re-arbitrate in the same cycle from the new ptr using the current request vector:
    - If a winner exists, grant moves to it at the next edge with cnt reloaded from its weight. There is no idle bubble.
    - Otherwise go to IDLE with grant=0.
  - If the owner is the only requester at release, it wins again back-to-back with a fresh cnt.
- Each non-stalled cycle with grant high and request[o]=1 consumes exactly one unit of burst.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid==|grant and grant_id matches grant.
  - grant never asserts to a client whose request was low in the cycle the grant decision was made.
- Fairness: with stall=0 and request[i] held high, client i is granted within the sum over j≠i of max(weight[j],1) cycles.
- Wrap-around: ptr increments modulo CLIENTS, so o=CLIENTS-1 releases to ptr=0.
- Counter width is WEIGHT_W; cnt never underflows because the minimum load is 1.

Test Plan:
- Reset mid-burst: client 2 granted with cnt=2, assert reset → grant=0 and grant_id=0 immediately (asynchronously). After deassertion, request=0x05 → client 0 is granted first.
- Single requester, CLIENTS=8: request=0x10, weight[4]=3 → grant=0x10 from cycle 1, continuous with no gap. Verify cnt reloads every 3 cycles and ptr stays at 5 after each release.
- Two requesters, weights 2 and 1: request=0x06, weight[1]=2, weight[2]=1 → grant sequence 0x02, 0x02, 0x04, 0x02, 0x02, 0x04…
- Early drop: client 3 granted with weight 4, request[3] falls after 1 cycle, request[6] high → grant moves to 0x40 on the next edge. weight[6]=0 → 0x40 is held 1 cycle only.
- Stall: client 0 granted with weight 3, stall high for 5 cycles in mid-burst → grant=0x01 frozen. After stall falls, the remaining 2 cycles complete. Stall in IDLE with request=0xFF → no grant until stall falls.
- Wrap-around and fairness: all requests high, all weights 1 → grant rotates 0x01→0x02→…→0x80→0x01. Each client is granted within 7 cycles of the previous grant.
